// File: rtl/ntt_agu_pkg.sv
// Shared types and helpers for the NTT address generation unit:
// FSM state encoding, stage-index width helper and butterfly index expansion.
package ntt_agu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int sidx_w(input int log_n);
    return (log_n > 1) ? $clog2(log_n) : 1;
  endfunction

  // Open a zero bit at position s: bits of t at and above s move up by one.
  function automatic logic [31:0] insert_zero(input logic [31:0] t, input logic [4:0] s);
    logic [31:0] lo_mask;
    lo_mask = (32'd1 << s) - 32'd1;
    return ((t & ~lo_mask) << 1) | (t & lo_mask);
  endfunction

endpackage

// File: rtl/ntt_agu_if.sv
// Beat/handshake bundle between the NTT controller, the AGU and the banked memory.
// The tw_idx signal exists only when NTT_AGU_TWIDDLE_EN is defined.
interface ntt_agu_if
  import ntt_agu_pkg::*;
#(
  parameter int LOG_N = 3,
  parameter int LOG_B = 1
) ();
  localparam int SW = sidx_w(LOG_N);

  logic                   start;
  logic                   inv;
  logic                   busy;
  logic                   out_valid;
  logic                   out_ready;
  logic [LOG_B-1:0]       bn_u;
  logic [LOG_B-1:0]       bn_l;
  logic [LOG_N-LOG_B-1:0] ma_u;
  logic [LOG_N-LOG_B-1:0] ma_l;
  logic [SW-1:0]          stage_idx;
  logic                   last;
  logic                   done;
`ifdef NTT_AGU_TWIDDLE_EN
  logic [LOG_N-2:0]       tw_idx;
`endif

  modport master (
    input  start, inv, out_ready,
    output busy, out_valid, bn_u, bn_l, ma_u, ma_l, stage_idx, last, done
`ifdef NTT_AGU_TWIDDLE_EN
    , output tw_idx
`endif
  );

  modport slave (
    output start, inv, out_ready,
    input  busy, out_valid, bn_u, bn_l, ma_u, ma_l, stage_idx, last, done
`ifdef NTT_AGU_TWIDDLE_EN
    , input tw_idx
`endif
  );

endinterface

// File: rtl/ntt_agu_map.sv
// Conflict-free bank mapping: bank = digit-sum of the LOG_B-bit groups of j
// (wrapping), memory address = j >> LOG_B.
module ntt_agu_map #(
  parameter int LOG_N = 3,
  parameter int LOG_B = 1
) (
  input  logic [LOG_N-1:0]       j_i,
  output logic [LOG_B-1:0]       bn_o,
  output logic [LOG_N-LOG_B-1:0] ma_o
);
  localparam int NDIG = (LOG_N + LOG_B - 1) / LOG_B;

  logic [NDIG*LOG_B-1:0] jx;

  always_comb begin
    jx = '0;
    jx[LOG_N-1:0] = j_i;
    bn_o = '0;
    for (int d = 0; d < NDIG; d++) bn_o = bn_o + jx[d*LOG_B +: LOG_B];
  end

  assign ma_o = j_i[LOG_N-1:LOG_B];

endmodule

// File: rtl/ntt_agu_pipe.sv
// Dual-operand NTT address generator with valid/ready output and per-job
// forward/inverse ordering. Optional tw_idx output: define NTT_AGU_TWIDDLE_EN.
module ntt_agu_pipe
  import ntt_agu_pkg::*;
#(
  parameter int LOG_N = 3,
  parameter int LOG_B = 1,
  parameter int ITER  = 1
) (
  input logic       clk,
  input logic       rst,
  ntt_agu_if.master bus
);
  localparam int SW = sidx_w(LOG_N);
  localparam int TW = LOG_N - 1;
  localparam int MW = LOG_N - LOG_B;
  localparam int IW = (ITER > 1) ? $clog2(ITER) : 1;

  state_e            state_q, state_d;
  logic [TW-1:0]     t_q, t_d;
  logic [SW-1:0]     p_q, p_d;
  logic [IW-1:0]     i_q, i_d;
  logic              inv_q, inv_d;
  logic              vld_q, vld_d;
  logic              last_q, last_d;
  logic              done_q, done_d;
  logic              load;
  logic [SW-1:0]     s_n, stg_q;
  logic [LOG_N-1:0]  u_n, l_n;
  logic [LOG_B-1:0]  bn_u_n, bn_l_n, bn_u_q, bn_l_q;
  logic [MW-1:0]     ma_u_n, ma_l_n, ma_u_q, ma_l_q;

  // Beat fields are derived from the next counter values and captured on load.
  assign s_n = inv_d ? p_d : SW'(LOG_N - 1) - p_d;
  assign u_n = LOG_N'(insert_zero(32'(t_d), 5'(s_n)));
  assign l_n = u_n | (LOG_N'(1) << s_n);

  ntt_agu_map #(.LOG_N(LOG_N), .LOG_B(LOG_B)) u_map_u (.j_i(u_n), .bn_o(bn_u_n), .ma_o(ma_u_n));
  ntt_agu_map #(.LOG_N(LOG_N), .LOG_B(LOG_B)) u_map_l (.j_i(l_n), .bn_o(bn_l_n), .ma_o(ma_l_n));

  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    p_d     = p_q;
    i_d     = i_q;
    inv_d   = inv_q;
    vld_d   = vld_q;
    last_d  = last_q;
    done_d  = 1'b0;
    load    = 1'b0;
    unique case (state_q)
      IDLE: if (bus.start) begin
        state_d = RUN;
        t_d     = '0;
        p_d     = '0;
        i_d     = '0;
        inv_d   = bus.inv;
        vld_d   = 1'b1;
        load    = 1'b1;
      end
      RUN: if (vld_q && bus.out_ready) begin
        if (last_q) begin
          state_d = DONE;
          vld_d   = 1'b0;
          last_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          load = 1'b1;
          if (t_q != '1) begin
            t_d = t_q + 1'b1;
          end else begin
            t_d = '0;
            if (p_q != SW'(LOG_N - 1)) begin
              p_d = p_q + 1'b1;
            end else begin
              p_d = '0;
              i_d = (i_q == IW'(ITER - 1)) ? '0 : i_q + 1'b1;
            end
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (load) last_d = (t_d == '1) && (p_d == SW'(LOG_N - 1)) && (i_d == IW'(ITER - 1));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      t_q     <= '0;
      p_q     <= '0;
      i_q     <= '0;
      inv_q   <= 1'b0;
      vld_q   <= 1'b0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
      bn_u_q  <= '0;
      bn_l_q  <= '0;
      ma_u_q  <= '0;
      ma_l_q  <= '0;
      stg_q   <= '0;
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
      p_q     <= p_d;
      i_q     <= i_d;
      inv_q   <= inv_d;
      vld_q   <= vld_d;
      last_q  <= last_d;
      done_q  <= done_d;
      if (load) begin
        bn_u_q <= bn_u_n;
        bn_l_q <= bn_l_n;
        ma_u_q <= ma_u_n;
        ma_l_q <= ma_l_n;
        stg_q  <= s_n;
      end
    end
  end

`ifdef NTT_AGU_TWIDDLE_EN
  logic [TW-1:0] tw_n, tw_q;
  logic [31:0]   tw_mask;

  // tw = (t mod 2^s) << (LOG_N-1-s)
  assign tw_mask = (32'd1 << s_n) - 32'd1;
  assign tw_n    = TW'((32'(t_d) & tw_mask) << (32'(LOG_N - 1) - 32'(s_n)));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)      tw_q <= '0;
    else if (load) tw_q <= tw_n;
  end

  assign bus.tw_idx = tw_q;
`endif

  assign bus.busy      = (state_q != IDLE);
  assign bus.out_valid = vld_q;
  assign bus.bn_u      = bn_u_q;
  assign bus.bn_l      = bn_l_q;
  assign bus.ma_u      = ma_u_q;
  assign bus.ma_l      = ma_l_q;
  assign bus.stage_idx = stg_q;
  assign bus.last      = last_q;
  assign bus.done      = done_q;

endmodule

// File: tb/tb_ntt_agu_pipe.sv
// Directed bench for ntt_agu_pipe: two instances (LOG_N=3/LOG_B=1/ITER=1 and
// LOG_N=4/LOG_B=2/ITER=2); tw_idx checks are compiled in with NTT_AGU_TWIDDLE_EN.
`timescale 1ns/1ps
module tb_ntt_agu_pipe;

  logic clk = 1'b0;
  logic rst;
  logic sel, start, inv, ready;

  always #5 clk = ~clk;

  ntt_agu_if #(.LOG_N(3), .LOG_B(1)) ia ();
  ntt_agu_if #(.LOG_N(4), .LOG_B(2)) ib ();

  ntt_agu_pipe #(.LOG_N(3), .LOG_B(1), .ITER(1)) dut_a (.clk(clk), .rst(rst), .bus(ia.master));
  ntt_agu_pipe #(.LOG_N(4), .LOG_B(2), .ITER(2)) dut_b (.clk(clk), .rst(rst), .bus(ib.master));

  assign ia.start     = start & ~sel;
  assign ia.inv       = inv;
  assign ia.out_ready = ready;
  assign ib.start     = start & sel;
  assign ib.inv       = inv;
  assign ib.out_ready = ready;

  int o_vld, o_busy, o_done, o_last, o_bu, o_mu, o_bl, o_ml, o_s, o_tw;

  always_comb begin
    if (sel) begin
      o_vld = int'(ib.out_valid); o_busy = int'(ib.busy); o_done = int'(ib.done);
      o_last = int'(ib.last); o_bu = int'(ib.bn_u); o_mu = int'(ib.ma_u);
      o_bl = int'(ib.bn_l); o_ml = int'(ib.ma_l); o_s = int'(ib.stage_idx);
`ifdef NTT_AGU_TWIDDLE_EN
      o_tw = int'(ib.tw_idx);
`else
      o_tw = 0;
`endif
    end else begin
      o_vld = int'(ia.out_valid); o_busy = int'(ia.busy); o_done = int'(ia.done);
      o_last = int'(ia.last); o_bu = int'(ia.bn_u); o_mu = int'(ia.ma_u);
      o_bl = int'(ia.bn_l); o_ml = int'(ia.ma_l); o_s = int'(ia.stage_idx);
`ifdef NTT_AGU_TWIDDLE_EN
      o_tw = int'(ia.tw_idx);
`else
      o_tw = 0;
`endif
    end
  end

  int n_chk = 0;
  int n_err = 0;
  int r_bu[64], r_mu[64], r_bl[64], r_ml[64], r_s[64], r_tw[64];

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s got=%0d want=%0d", tag, obs, exp);
    end
  endtask

  function automatic int bank(input int j, input int lb);
    int sum;
    sum = 0;
    while (j > 0) begin
      sum = sum + (j % (1 << lb));
      j = j >> lb;
    end
    return sum % (1 << lb);
  endfunction

  function automatic void model(input int ln, input int lb, input int it, input int k,
                                input bit iv, output int s, output int bu, output int mu,
                                output int bl, output int ml, output int tw, output int lst);
    int half, t, p, u, l;
    half = 1 << (ln - 1);
    t    = k % half;
    p    = (k / half) % ln;
    s    = iv ? p : ln - 1 - p;
    u    = ((t >> s) << (s + 1)) | (t % (1 << s));
    l    = u + (1 << s);
    bu   = bank(u, lb);
    bl   = bank(l, lb);
    mu   = u >> lb;
    ml   = l >> lb;
    tw   = (t % (1 << s)) << (ln - 1 - s);
    lst  = int'(k == it * ln * half - 1);
  endfunction

  task automatic chk_idle(input string nm);
    chk({nm, "_vld"}, o_vld, 0);
    chk({nm, "_busy"}, o_busy, 0);
    chk({nm, "_done"}, o_done, 0);
    chk({nm, "_last"}, o_last, 0);
    chk({nm, "_idx"}, o_bu + o_mu + o_bl + o_ml + o_s + o_tw, 0);
  endtask

  task automatic run_job(input bit s_b, input bit iv, input int stall_at, input string nm);
    int ln, lb, it, tot, k, cyc, stl;
    int es, ebu, emu, ebl, eml, etw, elst;
    ln = s_b ? 4 : 3;
    lb = s_b ? 2 : 1;
    it = s_b ? 2 : 1;
    tot = it * ln * (1 << (ln - 1));
    sel = s_b; inv = iv; ready = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    k = 0; cyc = 0; stl = 0;
    while (k < tot && cyc < 300) begin
      model(ln, lb, it, k, iv, es, ebu, emu, ebl, eml, etw, elst);
      chk({nm, "_vld"}, o_vld, 1);
      chk({nm, "_busy"}, o_busy, 1);
      chk({nm, "_bn_u"}, o_bu, ebu);
      chk({nm, "_ma_u"}, o_mu, emu);
      chk({nm, "_bn_l"}, o_bl, ebl);
      chk({nm, "_ma_l"}, o_ml, eml);
      chk({nm, "_stage"}, o_s, es);
      chk({nm, "_last"}, o_last, elst);
      chk({nm, "_bankdiff"}, int'(o_bu != o_bl), 1);
`ifdef NTT_AGU_TWIDDLE_EN
      chk({nm, "_tw"}, o_tw, etw);
`endif
      if (k < 64) begin
        r_bu[k] = o_bu; r_mu[k] = o_mu; r_bl[k] = o_bl; r_ml[k] = o_ml;
        r_s[k] = o_s; r_tw[k] = o_tw;
      end
      if (k == stall_at && stl < 3) begin
        ready = 1'b0;
        stl++;
      end else begin
        ready = 1'b1;
      end
      if (o_vld == 1 && ready) k++;
      @(posedge clk); #1;
      cyc++;
    end
    chk({nm, "_beats"}, k, tot);
    chk({nm, "_end_done"}, o_done, 1);
    chk({nm, "_end_busy"}, o_busy, 1);
    chk({nm, "_end_vld"}, o_vld, 0);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk({nm, "_post_done"}, o_done, 0);
    chk({nm, "_post_busy"}, o_busy, 0);
    chk({nm, "_post_vld"}, o_vld, 0);
  endtask

  initial begin
    rst = 1'b0; sel = 1'b0; start = 1'b0; inv = 1'b0; ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk_idle("rstA");
    sel = 1'b1; #1;
    chk_idle("rstB");
    sel = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;

    // Forward, LOG_N=3
    run_job(1'b0, 1'b0, -1, "fwd");
    chk("fwd_b0_s", r_s[0], 2);
    chk("fwd_b0_tuple", (r_bu[0] << 12) | (r_mu[0] << 8) | (r_bl[0] << 4) | r_ml[0], 'h0012);
    chk("fwd_b1_tuple", (r_bu[1] << 12) | (r_mu[1] << 8) | (r_bl[1] << 4) | r_ml[1], 'h1002);
`ifdef NTT_AGU_TWIDDLE_EN
    for (int t = 0; t < 4; t++) chk("tw_s2", r_tw[t], t);
    for (int t = 8; t < 12; t++) chk("tw_s0", r_tw[t], 0);
`endif

    // Inverse, LOG_N=3
    run_job(1'b0, 1'b1, -1, "inv");
    chk("inv_b0_s", r_s[0], 0);
    chk("inv_b0_tuple", (r_bu[0] << 12) | (r_mu[0] << 8) | (r_bl[0] << 4) | r_ml[0], 'h0010);
    chk("inv_b11_s", r_s[11], 2);
    chk("inv_b11_tuple", (r_bu[11] << 12) | (r_mu[11] << 8) | (r_bl[11] << 4) | r_ml[11], 'h0113);

    // Back-pressure: three stalled cycles on beat 5 (stage 1)
    run_job(1'b0, 1'b0, 5, "bp");

    // ITER=2, LOG_N=4, LOG_B=2, both orderings
    run_job(1'b1, 1'b0, 20, "it2f");
    run_job(1'b1, 1'b1, -1, "it2i");

    // Reset in the middle of beat 5
    sel = 1'b0; inv = 1'b0; ready = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("mid_stage_b5", o_s, 1);
    chk("mid_vld_b5", o_vld, 1);
    #2;
    rst = 1'b0;
    #1;
    chk_idle("arst");
    @(posedge clk); #1;
    chk_idle("arst_hold");
    rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      chk("arst_no_done", o_done, 0);
    end
    run_job(1'b0, 1'b0, -1, "restart");

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
